// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and constants for the data memory controller: FSM state
// encoding and the range of supported read latencies.
package data_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic logic lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// MEM-stage <-> data memory bus. The master drives requests, and the slave
// returns load data, strobes and the busy flag.
interface data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  // Handshake: a request is taken on a rising edge when write_enable or
  // read_enable is high and busy is low (busy acts as not-ready). There is no
  // backpressure on responses: read_valid and addr_err are one-cycle strobes
  // that the master must consume in the cycle they are high.
  logic                  write_enable;
  logic                  read_enable;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     read_data_out;
  logic                  read_valid;
  logic                  busy;
  logic                  addr_err;

  modport master (
    output write_enable, read_enable, addr, data_in, byte_en,
    input  read_data_out, read_valid, busy, addr_err
  );

  modport slave (
    input  write_enable, read_enable, addr, data_in, byte_en,
    output read_data_out, read_valid, busy, addr_err
  );
endinterface

// File: rtl/data_memory_ctrl_read_pipe.sv
// LAT-deep {valid, data} delay line. Each stage loads data only when its
// incoming valid is set, so the last stage doubles as the hold-last-value output.
module read_pipe #(
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              i_flush_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [LAT-1:0]    r_v;
  logic [DATA_W-1:0] r_d [LAT];

  always_ff @(posedge clk or negedge i_flush_n) begin
    if (!i_flush_n) begin
      r_v <= '0;
      for (int s = 0; s < LAT; s++) r_d[s] <= '0;
    end else begin
      r_v[0] <= i_valid;
      if (i_valid) r_d[0] <= i_data;
      for (int s = 1; s < LAT; s++) begin
        r_v[s] <= r_v[s-1];
        if (r_v[s-1]) r_d[s] <= r_d[s-1];
      end
    end
  end

  assign o_valid = r_v[LAT-1];
  assign o_data  = r_d[LAT-1];

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-addressed single-port data memory with byte enables, pipelined reads,
// out-of-range detection and a one-word-per-cycle clear after reset.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 256,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus,
  output state_t     o_dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_t            r_state;
  logic [PTR_W-1:0]  r_clr_ptr;
  logic              r_busy;
  logic              r_addr_err;

  logic              w_open;
  logic              w_in_range;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_bad_req;
  logic              w_clearing;
  logic              w_mem_we;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_mem_idx;
  logic [NB-1:0]     w_mem_be;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rd_word;

  a_lat_legal: assert property (@(posedge clk) lat_legal(READ_LAT));

  // Gating on r_busy too keeps the first post-reset edge closed when the
  // clear sequence is skipped, so busy and acceptance always agree.
  assign w_open     = (r_state == ST_IDLE) && !r_busy;
  assign w_in_range = {1'b0, bus.addr} < (ADDR_W+1)'(DEPTH);
  assign w_idx      = bus.addr[PTR_W-1:0];
  assign w_wr_fire  = w_open && bus.write_enable && w_in_range;
  assign w_rd_fire  = w_open && bus.read_enable && !bus.write_enable && w_in_range;
  assign w_bad_req  = w_open && (bus.write_enable || bus.read_enable) && !w_in_range;
  assign w_clearing = (r_state == ST_CLEAR);

  assign w_mem_we    = w_clearing || w_wr_fire;
  assign w_mem_idx   = w_clearing ? r_clr_ptr : w_idx;
  assign w_mem_be    = w_clearing ? '1 : bus.byte_en;
  assign w_mem_wdata = w_clearing ? '0 : bus.data_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_ptr  <= '0;
      r_busy     <= 1'b1;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_bad_req;
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + PTR_W'(1);
          if (r_clr_ptr == LAST_PTR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE:  r_busy  <= 1'b0;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // One byte-wide array per lane keeps the per-byte write enables independent.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk) begin
      if (w_mem_we && w_mem_be[b]) r_lane[w_mem_idx] <= w_mem_wdata[8*b +: 8];
    end

    assign w_rd_word[8*b +: 8] = r_lane[w_idx];
  end

  read_pipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LAT)
  ) u_read_pipe (
    .clk       (clk),
    .i_flush_n (reset),
    .i_valid   (w_rd_fire),
    .i_data    (w_rd_word),
    .o_valid   (bus.read_valid),
    .o_data    (bus.read_data_out)
  );

  assign bus.busy     = r_busy;
  assign bus.addr_err = r_addr_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: READ_LAT=1 and READ_LAT=2 instances driven in
// lockstep, checked against a reference memory model and per-instance queues.
module tb_data_memory_ctrl;
  import data_mem_pkg::*;

  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  data_mem_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();
  state_t st1, st2;

  data_memory_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1.slave), .o_dbg_state(st1)
  );

  data_memory_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1)
  ) u_dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2.slave), .o_dbg_state(st2)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int accept_from = 32'h7fff_ffff;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];
  int          due_q1[$];
  int          due_q2[$];
  int          err_q1[$];
  int          err_q2[$];

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
    logic [15:0] exp_d;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  logic [15:0] md1, md2;
  int          mt1, mt2;

  always @(negedge clk) begin
    if (bus1.read_valid) begin
      checks++;
      if (exp_q1.size() == 0) begin
        failures++;
        $display("FAIL lat1_unexpected_valid got data=%h exp=no strobe (cyc %0d)", bus1.read_data_out, cyc);
      end else begin
        md1 = exp_q1.pop_front();
        mt1 = due_q1.pop_front();
        if (bus1.read_data_out !== md1 || cyc != mt1) begin
          failures++;
          $display("FAIL lat1_read got=%h@%0d exp=%h@%0d", bus1.read_data_out, cyc, md1, mt1);
        end
      end
    end else if (due_q1.size() != 0 && due_q1[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL lat1_missing_valid got=none exp=%h@%0d", exp_q1[0], due_q1[0]);
      void'(exp_q1.pop_front());
      void'(due_q1.pop_front());
    end
    if (bus1.addr_err) begin
      checks++;
      if (err_q1.size() == 0 || err_q1[0] != cyc) begin
        failures++;
        $display("FAIL lat1_unexpected_addr_err got=1 exp=0 (cyc %0d)", cyc);
      end else void'(err_q1.pop_front());
    end else if (err_q1.size() != 0 && err_q1[0] <= cyc) begin
      checks++;
      failures++;
      $display("FAIL lat1_missing_addr_err got=0 exp=1 (cyc %0d)", err_q1[0]);
      void'(err_q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus2.read_valid) begin
      checks++;
      if (exp_q2.size() == 0) begin
        failures++;
        $display("FAIL lat2_unexpected_valid got data=%h exp=no strobe (cyc %0d)", bus2.read_data_out, cyc);
      end else begin
        md2 = exp_q2.pop_front();
        mt2 = due_q2.pop_front();
        if (bus2.read_data_out !== md2 || cyc != mt2) begin
          failures++;
          $display("FAIL lat2_read got=%h@%0d exp=%h@%0d", bus2.read_data_out, cyc, md2, mt2);
        end
      end
    end else if (due_q2.size() != 0 && due_q2[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL lat2_missing_valid got=none exp=%h@%0d", exp_q2[0], due_q2[0]);
      void'(exp_q2.pop_front());
      void'(due_q2.pop_front());
    end
    if (bus2.addr_err) begin
      checks++;
      if (err_q2.size() == 0 || err_q2[0] != cyc) begin
        failures++;
        $display("FAIL lat2_unexpected_addr_err got=1 exp=0 (cyc %0d)", cyc);
      end else void'(err_q2.pop_front());
    end else if (err_q2.size() != 0 && err_q2[0] <= cyc) begin
      checks++;
      failures++;
      $display("FAIL lat2_missing_addr_err got=0 exp=1 (cyc %0d)", err_q2[0]);
      void'(err_q2.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the request is sampled at the next posedge (cyc+1).
  task automatic step(input logic we, input logic re, input logic [15:0] addr,
                      input logic [15:0] din, input logic [1:0] be,
                      input logic use_exp, input logic [15:0] exp_d);
    logic ok;
    logic [15:0] rd;
    bus1.write_enable = we;  bus2.write_enable = we;
    bus1.read_enable  = re;  bus2.read_enable  = re;
    bus1.addr = addr;        bus2.addr = addr;
    bus1.data_in = din;      bus2.data_in = din;
    bus1.byte_en = be;       bus2.byte_en = be;
    ok = rst_n && (cyc >= accept_from);
    if (ok && (we || re) && addr >= 16'(DEPTH)) begin
      err_q1.push_back(cyc + 1);
      err_q2.push_back(cyc + 1);
    end else if (ok && re && !we) begin
      rd = use_exp ? exp_d : model_mem[addr[7:0]];
      exp_q1.push_back(rd);  due_q1.push_back(cyc + 1);
      exp_q2.push_back(rd);  due_q2.push_back(cyc + 2);
    end else if (ok && we) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) model_mem[addr[7:0]][8*b +: 8] = din[8*b +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    exp_q1.delete(); due_q1.delete(); err_q1.delete();
    exp_q2.delete(); due_q2.delete(); err_q2.delete();
    accept_from = 32'h7fff_ffff;
    #1;
    chk("rst_busy_lat1", 32'(bus1.busy), 32'd1);
    chk("rst_busy_lat2", 32'(bus2.busy), 32'd1);
    chk("rst_valid_lat1", 32'(bus1.read_valid), 32'd0);
    chk("rst_valid_lat2", 32'(bus2.read_valid), 32'd0);
    chk("rst_data_lat1", 32'(bus1.read_data_out), 32'h0);
    chk("rst_data_lat2", 32'(bus2.read_data_out), 32'h0);
    chk("rst_addr_err_lat1", 32'(bus1.addr_err), 32'd0);
    chk("rst_state_lat1", 32'(st1), 32'(ST_CLEAR));
    chk("rst_state_lat2", 32'(st2), 32'(ST_CLEAR));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0;
    accept_from = cyc + DEPTH;
  endtask

  task automatic release_and_count();
    int n1, n2;
    release_reset();
    #1;
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!bus1.busy && !bus2.busy) break;
      if (bus1.busy) n1++;
      if (bus2.busy) n2++;
      @(negedge clk);
      #1;
    end
    chk("clear_busy_cycles_lat1", n1, DEPTH);
    chk("clear_busy_cycles_lat2", n2, DEPTH);
    chk("idle_state_lat1", 32'(st1), 32'(ST_IDLE));
    chk("idle_state_lat2", 32'(st2), 32'(ST_IDLE));
  endtask

  task automatic add_vec(input logic we, input logic re, input logic [15:0] addr,
                         input logic [15:0] din, input logic [1:0] be, input logic [15:0] exp_d);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.din = din; v.be = be; v.exp_d = exp_d;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished (cyc %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    bus1.write_enable = 1'b0; bus2.write_enable = 1'b0;
    bus1.read_enable  = 1'b0; bus2.read_enable  = 1'b0;
    bus1.addr = '0;    bus2.addr = '0;
    bus1.data_in = '0; bus2.data_in = '0;
    bus1.byte_en = '0; bus2.byte_en = '0;

    // Directed vectors, applied from a clean (cleared) memory.
    add_vec(1, 0, 16'h0000, 16'h0666, 2'b11, 16'h0000);
    add_vec(0, 1, 16'h0000, 16'h0000, 2'b00, 16'h0666);
    add_vec(0, 1, 16'h00FF, 16'h0000, 2'b00, 16'h0000);
    add_vec(1, 0, 16'h0005, 16'hABCD, 2'b11, 16'h0000);
    add_vec(1, 0, 16'h0005, 16'h1234, 2'b01, 16'h0000);
    add_vec(0, 1, 16'h0005, 16'h0000, 2'b00, 16'hAB34);
    add_vec(1, 0, 16'h0005, 16'hFFFF, 2'b00, 16'h0000);
    add_vec(1, 0, 16'h0005, 16'hEE00, 2'b10, 16'h0000);
    add_vec(0, 1, 16'h0005, 16'h0000, 2'b00, 16'hEE34);
    add_vec(0, 1, 16'h0100, 16'h0000, 2'b00, 16'h0000);
    add_vec(1, 0, 16'h01FF, 16'hDEAD, 2'b11, 16'h0000);
    add_vec(0, 1, 16'h00FF, 16'h0000, 2'b00, 16'h0000);
    add_vec(1, 1, 16'h0003, 16'h5555, 2'b11, 16'h0000);
    add_vec(0, 1, 16'h0003, 16'h0000, 2'b00, 16'h5555);
    add_vec(1, 0, 16'h000A, 16'hA1A1, 2'b11, 16'h0000);
    add_vec(0, 1, 16'h000A, 16'h0000, 2'b00, 16'hA1A1);
    add_vec(1, 0, 16'h000A, 16'hB2B2, 2'b11, 16'h0000);
    add_vec(0, 1, 16'h000A, 16'h0000, 2'b00, 16'hB2B2);
    add_vec(0, 1, 16'h0000, 16'h0000, 2'b00, 16'h0666);
    add_vec(0, 1, 16'h0003, 16'h0000, 2'b00, 16'h5555);
    add_vec(0, 1, 16'h0005, 16'h0000, 2'b00, 16'hEE34);

    repeat (3) @(negedge clk);
    assert_reset();
    release_and_count();

    foreach (vecs[i])
      step(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din, vecs[i].be, 1'b1, vecs[i].exp_d);
    idle(3);
    chk("hold_after_reads_lat1", 32'(bus1.read_data_out), 32'hEE34);
    chk("hold_after_reads_lat2", 32'(bus2.read_data_out), 32'hEE34);

    // An out-of-range read must leave the held data alone.
    step(0, 1, 16'h0003, 16'h0, 2'b00, 1'b1, 16'h5555);
    idle(3);
    step(0, 1, 16'hFF00, 16'h0, 2'b00, 1'b0, 16'h0);
    idle(3);
    chk("hold_after_addr_err_lat1", 32'(bus1.read_data_out), 32'h5555);
    chk("hold_after_addr_err_lat2", 32'(bus2.read_data_out), 32'h5555);

    // Random traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 16'(16'h0100 + $urandom_range(0, 4000))
                                      : 16'($urandom_range(0, 15));
      step(r < 4, r >= 3, a, 16'($urandom), 2'($urandom_range(0, 3)), 1'b0, 16'h0);
    end
    idle(3);

    // Reset with a READ_LAT=2 read still in flight.
    step(1, 0, 16'h0007, 16'h7E7E, 2'b11, 1'b0, 16'h0);
    step(0, 1, 16'h0007, 16'h0, 2'b00, 1'b1, 16'h7E7E);
    #2;
    assert_reset();
    idle(3);
    chk("inflight_dropped_valid_lat2", 32'(bus2.read_valid), 32'd0);
    chk("inflight_dropped_data_lat2", 32'(bus2.read_data_out), 32'h0);

    // Reset again at cycle 100 of the clear, with requests offered while clearing.
    release_reset();
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1) == 1, 1'b1, 16'($urandom_range(0, 511)), 16'hFFFF, 2'b11, 1'b0, 16'h0);
    #2;
    assert_reset();
    idle(2);
    release_and_count();

    step(0, 1, 16'h00FF, 16'h0, 2'b00, 1'b1, 16'h0000);
    step(0, 1, 16'h0007, 16'h0, 2'b00, 1'b1, 16'h0000);
    step(0, 1, 16'h0100, 16'h0, 2'b00, 1'b0, 16'h0);
    idle(4);

    chk("scoreboard_drained_lat1", 32'(exp_q1.size() + err_q1.size()), 32'd0);
    chk("scoreboard_drained_lat2", 32'(exp_q2.size() + err_q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
